// File: rtl/fpga_data_source_pkg.sv
// Register map, bit positions, state encoding and LFSR taps shared by the
// fpga_data_source packet generator and its lfsr8 helper.
package fpga_data_source_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CNT  = 2'd3;

    localparam int CTRL_START    = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_MODE     = 2;
    localparam int CTRL_SEED_LSB = 8;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_ABORTED  = 2;
    localparam int STAT_LAST_LSB = 8;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // One Fibonacci step of x^8+x^6+x^5+x^4+1: shift left, XOR of taps into b0.
    function automatic logic [7:0] lfsrStep(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Combinational next-state function of the 8-bit pattern LFSR used by
// fpga_data_source when LFSR mode is built in.
module lfsr8
    import fpga_data_source_pkg::*;
(
    input  logic [7:0] state_i,
    output logic [7:0] next_o
);

    assign next_o = lfsrStep(state_i);

endmodule

// File: rtl/fpga_data_source.sv
// Avalon-MM programmed packet generator driving an 8-bit AXI4-Stream master.
// Optional LFSR pattern mode is built in when FPGA_DATA_SOURCE_LFSR_EN is defined.
module fpga_data_source
    import fpga_data_source_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_chipselect,
    input  logic        avs_write_n,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [7:0]  axis4_m_tdata,
    output logic        axis4_m_tvalid,
    output logic        axis4_m_tlast,
    input  logic        axis4_m_tready
);

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  seed_q, seed_d;
    logic [7:0]  curByte_q, curByte_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [7:0]  lastByte_q, lastByte_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic        abortPend_q, abortPend_d;

    logic        wrEn;
    logic        ctrlWr;
    logic        startReq;
    logic        abortReq;
    logic        sending;
    logic        tlastInt;
    logic        handshake;
    logic [7:0]  nextByte;
    logic [7:0]  startByte;
    logic        modeView;
    logic        unusedWd;

`ifdef FPGA_DATA_SOURCE_LFSR_EN
    logic        mode_q, mode_d;
    logic        workMode_q, workMode_d;
    logic [7:0]  lfsrNext;
    logic [7:0]  wrSeed;

    lfsr8 u_lfsr8 (
        .state_i (curByte_q),
        .next_o  (lfsrNext)
    );

    assign modeView  = mode_q;
    assign nextByte  = workMode_q ? lfsrNext : curByte_q + 8'd1;
    assign wrSeed    = avs_writedata[CTRL_SEED_LSB +: 8];
    // The all-zero state would lock the LFSR, so a zero seed starts at 0x01.
    assign startByte = (avs_writedata[CTRL_MODE] && wrSeed == 8'd0) ? 8'h01 : wrSeed;
    assign unusedWd  = ^{avs_writedata[31:16], avs_writedata[7:3]};
`else
    assign modeView  = 1'b0;
    assign nextByte  = curByte_q + 8'd1;
    assign startByte = avs_writedata[CTRL_SEED_LSB +: 8];
    assign unusedWd  = ^{avs_writedata[31:16], avs_writedata[7:2]};
`endif

    assign wrEn      = avs_chipselect & ~avs_write_n;
    assign ctrlWr    = wrEn && (avs_address == REG_CTRL);
    assign startReq  = ctrlWr && avs_writedata[CTRL_START];
    assign abortReq  = ctrlWr && avs_writedata[CTRL_ABORT];
    assign sending   = (state_q == ST_SEND);
    assign tlastInt  = sending && ((remaining_q == 8'd0) || abortPend_q);
    assign handshake = sending && axis4_m_tready;

    assign axis4_m_tvalid = sending;
    assign axis4_m_tlast  = tlastInt;
    assign axis4_m_tdata  = sending ? curByte_q : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= 8'd0;
            seed_q      <= 8'd0;
            curByte_q   <= 8'd0;
            remaining_q <= 8'd0;
            cnt_q       <= 9'd0;
            lastByte_q  <= 8'd0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            abortPend_q <= 1'b0;
`ifdef FPGA_DATA_SOURCE_LFSR_EN
            mode_q      <= 1'b0;
            workMode_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            seed_q      <= seed_d;
            curByte_q   <= curByte_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            lastByte_q  <= lastByte_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            abortPend_q <= abortPend_d;
`ifdef FPGA_DATA_SOURCE_LFSR_EN
            mode_q      <= mode_d;
            workMode_q  <= workMode_d;
`endif
        end
    end

    // Register view updates always; working copies change only on an accepted START.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        seed_d      = seed_q;
        curByte_d   = curByte_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        lastByte_d  = lastByte_q;
        done_d      = done_q;
        aborted_d   = aborted_q;
        abortPend_d = abortPend_q;
`ifdef FPGA_DATA_SOURCE_LFSR_EN
        mode_d      = mode_q;
        workMode_d  = workMode_q;
        if (ctrlWr) begin
            mode_d = avs_writedata[CTRL_MODE];
        end
`endif
        if (ctrlWr) begin
            seed_d = avs_writedata[CTRL_SEED_LSB +: 8];
        end
        if (wrEn && (avs_address == REG_LEN)) begin
            len_d = avs_writedata[7:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (startReq) begin
                    state_d     = ST_SEND;
                    curByte_d   = startByte;
                    remaining_d = len_q;
                    cnt_d       = 9'd0;
                    done_d      = 1'b0;
                    aborted_d   = 1'b0;
                    abortPend_d = 1'b0;
`ifdef FPGA_DATA_SOURCE_LFSR_EN
                    workMode_d  = avs_writedata[CTRL_MODE];
`endif
                end
            end
            ST_SEND: begin
                if (abortReq) begin
                    abortPend_d = 1'b1;
                end
                if (handshake) begin
                    cnt_d      = cnt_q + 9'd1;
                    lastByte_d = curByte_q;
                    if (tlastInt) begin
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                        aborted_d   = abortPend_q;
                        abortPend_d = 1'b0;
                    end else begin
                        curByte_d   = nextByte;
                        remaining_d = remaining_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        avs_readdata = 32'd0;
        case (avs_address)
            REG_CTRL: avs_readdata = {16'd0, seed_q, 5'd0, modeView, 2'b00};
            REG_STAT: avs_readdata = {16'd0, lastByte_q, 5'd0, aborted_q, done_q, sending};
            REG_LEN:  avs_readdata = {24'd0, len_q};
            REG_CNT:  avs_readdata = {23'd0, cnt_q};
            default:  avs_readdata = 32'd0;
        endcase
    end

endmodule
